// File: rtl/comparator_floating_point.sv
// Registered binary32 comparator: one less/equal/greater/unordered decision per
// accepted operand pair, presented one clock after acceptance.
module comparator_floating_point (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        l,
  output logic        e,
  output logic        g,
  output logic        unordered,
  output logic        out_valid
);

  // Handshake: no backpressure. A pair is accepted on every rising edge where
  // in_valid=1; its result is shown for the following cycle with out_valid=1.
  // While in_valid=0 the result flags keep the last accepted decision.

  logic        nan1, nan2;
  logic        both_zero;
  logic        sign1, sign2;
  logic [30:0] mag1, mag2;
  logic        mag_lt, mag_eq;
  logic        l_c, e_c, g_c, u_c;

  assign sign1 = in1[31];
  assign sign2 = in2[31];
  assign mag1  = in1[30:0];
  assign mag2  = in2[30:0];

  assign nan1      = (in1[30:23] == 8'hff) && (in1[22:0] != 23'd0);
  assign nan2      = (in2[30:23] == 8'hff) && (in2[22:0] != 23'd0);
  assign both_zero = (mag1 == 31'd0) && (mag2 == 31'd0);

  // Sign-magnitude encoding makes the unsigned compare of bits[30:0] exact for
  // every non-NaN value, denormals and infinities included.
  assign mag_lt = mag1 < mag2;
  assign mag_eq = mag1 == mag2;

  always_comb begin
    l_c = 1'b0;
    e_c = 1'b0;
    g_c = 1'b0;
    u_c = 1'b0;
    if (nan1 || nan2) begin
      u_c = 1'b1;
    end else if (both_zero) begin
      e_c = 1'b1;
    end else if (sign1 != sign2) begin
      l_c = sign1;
      g_c = sign2;
    end else if (!sign1) begin
      l_c = mag_lt;
      e_c = mag_eq;
      g_c = !mag_lt && !mag_eq;
    end else begin
      // Both negative: larger magnitude is the lesser value.
      g_c = mag_lt;
      e_c = mag_eq;
      l_c = !mag_lt && !mag_eq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l         <= 1'b0;
      e         <= 1'b0;
      g         <= 1'b0;
      unordered <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        l         <= l_c;
        e         <= e_c;
        g         <= g_c;
        unordered <= u_c;
      end
    end
  end

endmodule

// File: tb/tb_comparator_floating_point.sv
// Bench for comparator_floating_point: directed and random pairs checked by a
// scoreboard against an ordering-key reference model.
module tb_comparator_floating_point;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in1, in2;
  logic        l, e, g, unordered, out_valid;

  logic [3:0] exp_q[$];
  logic [3:0] last_exp;
  int         tests;
  int         fails;

  comparator_floating_point dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .l         (l),
    .e         (e),
    .g         (g),
    .unordered (unordered),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  // Signed ordering key: -m for negatives, +m for positives, so +0 and -0 map
  // to the same key and plain integer ordering gives the float ordering.
  function automatic longint order_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  // Result packed as {l, e, g, unordered}.
  function automatic logic [3:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if (is_nan(a) || is_nan(b)) return 4'b0001;
    ka = order_key(a);
    kb = order_key(b);
    if (ka < kb)  return 4'b1000;
    if (ka == kb) return 4'b0100;
    return 4'b0010;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic v);
    @(negedge clk);
    in1      = a;
    in2      = b;
    in_valid = v;
    if (v) exp_q.push_back(ref_cmp(a, b));
  endtask

  task automatic idle();
    send($urandom, $urandom, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [3:0] exp;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp = exp_q.pop_front();
        last_exp = exp;
        check("result_legu", {28'd0, l, e, g, unordered}, {28'd0, exp});
      end
    end else begin
      check("hold_legu", {28'd0, l, e, g, unordered}, {28'd0, last_exp});
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] specials [0:11];

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return specials[$urandom_range(0, 11)];
    if (r == 1) return {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)), 23'($urandom)};
    return $urandom;
  endfunction

  initial begin
    logic [31:0] a, b;
    tests    = 0;
    fails    = 0;
    last_exp = 4'b0000;
    specials = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h80000001,
                 32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h7f800001,
                 32'h7f7fffff, 32'hff7fffff, 32'h3f800000, 32'hbf800000};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    #3;
    check("reset_state", {27'd0, l, e, g, unordered, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    send(32'h3e999999, 32'h3f99999a, 1'b1);
    send(32'h3f99999a, 32'h3e999999, 1'b1);
    send(32'h3f99999a, 32'h42c80000, 1'b1);
    send(32'h42c80000, 32'h3f99999a, 1'b1);
    send(32'h42c80000, 32'h42c80000, 1'b1);
    send(32'hc0000000, 32'hbf800000, 1'b1);
    send(32'hbf800000, 32'h3e999999, 1'b1);
    send(32'h00000000, 32'h80000000, 1'b1);
    send(32'h00000001, 32'h00000000, 1'b1);
    send(32'h7fc00000, 32'h3f800000, 1'b1);
    send(32'h7f800000, 32'h7f7fffff, 1'b1);
    send(32'hff800000, 32'hff800000, 1'b1);
    send(32'h3f800000, 32'h7f800001, 1'b1);
    // Hold: invalid cycles with fresh operands must not disturb the outputs.
    send(32'h7fc00000, 32'h7fc00000, 1'b0);
    send(32'h00000000, 32'h3f800000, 1'b0);
    send(32'hbf800000, 32'h3f800000, 1'b1);
    idle();

    // Reset between edges with a pair on the inputs: must not surface.
    @(negedge clk);
    in1      = 32'h3f800000;
    in2      = 32'h3f800000;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_exp = 4'b0000;
    #1;
    check("async_reset", {27'd0, l, e, g, unordered, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle();

    // Random traffic, including equal and sign-flipped pairs.
    for (int i = 0; i < 400; i++) begin
      a = pick();
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = pick();
      endcase
      send(a, b, $urandom_range(0, 3) != 0);
    end
    idle();
    idle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
